dm_bus_bridge: RTL and testbench

// - Sits between the core's data-memory port (DM_*) and a multi-cycle req/ack memory bus.
// - Turns each single-cycle DM access into a bus transaction.
// - Drives the core's stall input until the access completes.
// - Returns read data in the exact cycle the core's MEM/WB register samples it.

---
 rtl/dm_bus_bridge.sv | 147 ++++++++++++++
 tb/tb_dm_bus_bridge.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bus_bridge.sv
// dm_bus_bridge: turns single-cycle data-memory accesses from the core into
// req/ack bus transactions and stalls the core until each access completes.
// Optional feature: define DM_BRIDGE_TIMEOUT_EN to abort a bus transaction
// after TIMEOUT_CYC cycles without mem_ack (err pulse, 32'hDEAD_BEEF load data).
module dm_bus_bridge #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_en,
    input  logic              cpu_write,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_stall,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              timeout_hit;
    logic              unused_bits;

`ifdef DM_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Abort fires at the end of the TIMEOUT_CYC-th BUSY cycle; a same-cycle ack wins.
    assign timeout_hit = (state_q == BUSY) && !mem_ack && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Count BUSY cycles without ack; cleared when a new access is accepted.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && cpu_en) begin
            cnt_d = '0;
        end else if (state_q == BUSY && !mem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Byte-lane address bits are intentionally dropped on the word bus.
    assign unused_bits = ^cpu_addr[1:0];
`else
    assign timeout_hit = 1'b0;
    assign unused_bits = ^{cpu_addr[1:0], TIMEOUT_CYC[0]};
`endif

    // Next-state and request/response register updates.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_en) begin
                    addr_d  = cpu_addr[ADDR_W-1:2];
                    we_d    = cpu_write;
                    wdata_d = cpu_wdata;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = DATA_W'(32'hDEAD_BEEF);
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                // The core still presents the finished access here, so it is not re-sampled.
                if (!ext_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // BUSY is masked during reset so the core sees only ext_stall and a new request.
    always_comb begin
        stall = ext_stall | ((state_q == IDLE) & cpu_en) | ((state_q == BUSY) & !rst);
    end

    assign mem_req   = (state_q == BUSY);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dm_bus_bridge.sv
// Self-checking bench for dm_bus_bridge: the bench plays both the core and the
// bus; expected bus requests and load results go into scoreboard queues at issue
// time and are popped when the DUT presents them.
module tb_dm_bus_bridge;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
`ifdef DM_BRIDGE_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_en;
    logic          cpu_write;
    logic [DW-1:0] cpu_rdata;
    logic          ext_stall;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-3:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          err;

    always #5 clk = ~clk;

    dm_bus_bridge #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_en    (cpu_en),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .ext_stall (ext_stall),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    typedef struct packed {
        logic          we;
        logic [AW-3:0] addr;
        logic [DW-1:0] wdata;
    } bus_t;

    bus_t          bus_q[$];
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] last_rd = '0;
    int            n_vec = 0;
    int            n_err = 0;
    int            exp_rises = 0;
    int            rises = 0;
    logic          req_prev = 1'b0;

    // Count bus transactions by mem_req rising edges.
    always @(negedge clk) begin
        if (mem_req && !req_prev) rises <= rises + 1;
        req_prev <= mem_req;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // IDLE cycle: present an access and record what the bus and core should see.
    task automatic issue(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] bus_rd);
        bus_t e;
        @(negedge clk);
        cpu_en    = 1'b1;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        ext_stall = 1'b0;
        mem_ack   = 1'b0;
        e.we    = wr;
        e.addr  = addr[AW-1:2];
        e.wdata = wd;
        bus_q.push_back(e);
        rd_q.push_back(wr ? last_rd : bus_rd);
        if (!wr) last_rd = bus_rd;
        exp_rises++;
        #1;
        check_eq("idle_stall", 64'(stall), 64'(1'b1));
        check_eq("idle_req", 64'(mem_req), 64'(1'b0));
    endtask

    // BUSY cycles: bus responds with ack in the n-th cycle.
    task automatic busy(input int unsigned n, input logic [DW-1:0] bus_rd);
        bus_t e;
        e = bus_q.pop_front();
        for (int unsigned k = 1; k <= n; k++) begin
            @(negedge clk);
            mem_ack   = (k == n);
            mem_rdata = (k == n) ? bus_rd : DW'($urandom);
            #1;
            check_eq("busy_req", 64'(mem_req), 64'(1'b1));
            check_eq("busy_we", 64'(mem_we), 64'(e.we));
            check_eq("busy_addr", 64'(mem_addr), 64'(e.addr));
            check_eq("busy_wdata", 64'(mem_wdata), 64'(e.wdata));
            check_eq("busy_stall", 64'(stall), 64'(1'b1));
        end
    endtask

    // RESP: optionally held by ext_stall for 'hold' cycles, then released.
    task automatic resp(input int unsigned hold);
        logic [DW-1:0] e;
        logic          exp_stall;
        e = rd_q.pop_front();
        for (int unsigned k = 0; k <= hold; k++) begin
            @(negedge clk);
            mem_ack   = 1'b0;
            exp_stall = (k < hold);
            ext_stall = exp_stall;
            #1;
            check_eq("resp_stall", 64'(stall), 64'(exp_stall));
            check_eq("resp_rdata", 64'(cpu_rdata), 64'(e));
            check_eq("resp_req", 64'(mem_req), 64'(1'b0));
            check_eq("resp_err", 64'(err), 64'(1'b0));
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        cpu_en    = 1'b0;
        cpu_write = 1'b0;
        mem_ack   = 1'b0;
        ext_stall = 1'b0;
        #1;
        check_eq("idle_nostall", 64'(stall), 64'(1'b0));
        check_eq("idle_noreq", 64'(mem_req), 64'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cpu_en = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_stall = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset: stall follows IDLE & cpu_en, registers come up cleared.
        @(negedge clk);
        @(negedge clk);
        cpu_en = 1'b1;
        #1;
        check_eq("rst_stall", 64'(stall), 64'(1'b1));
        @(negedge clk);
        cpu_en = 1'b0;
        #1;
        check_eq("rst_req", 64'(mem_req), 64'(1'b0));
        check_eq("rst_we", 64'(mem_we), 64'(1'b0));
        check_eq("rst_addr", 64'(mem_addr), 64'(0));
        check_eq("rst_wdata", 64'(mem_wdata), 64'(0));
        check_eq("rst_rdata", 64'(cpu_rdata), 64'(0));
        check_eq("rst_err", 64'(err), 64'(1'b0));
        rst = 1'b0;
        idle_cycle();

        // Load, ack in first BUSY cycle: mem_addr 0x41.
        issue(1'b0, 32'h0000_0104, 32'h0, 32'h1234_5678);
        @(negedge clk);
        #1;
        check_eq("load_addr41", 64'(mem_addr), 64'h41);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        void'(bus_q.pop_front());
        resp(0);
        idle_cycle();

        // Store with ack after 4 cycles: cpu_rdata keeps the last load value.
        issue(1'b1, 32'h2000_0008, 32'hA5A5_A5A5, 32'h0);
        busy(4, 32'h7777_7777);
        resp(0);
        idle_cycle();

        // Back-to-back load then store, cpu_en held high across RESP.
        issue(1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D);
        busy(2, 32'hCAFE_F00D);
        resp(0);
        issue(1'b1, 32'h0000_0304, 32'h1357_9BDF, 32'h0);
        busy(1, 32'h5555_AAAA);
        resp(0);
        idle_cycle();

        // ext_stall holds RESP for 3 cycles, then release to IDLE.
        issue(1'b0, 32'h0000_0FFC, 32'h0, 32'h0BAD_F00D);
        busy(3, 32'h0BAD_F00D);
        resp(3);
        idle_cycle();

        // Misaligned byte address: low bits dropped.
        issue(1'b0, 32'hFFFF_FFFF, 32'h0, 32'h8000_0001);
        busy(1, 32'h8000_0001);
        resp(0);
        idle_cycle();

        // Reset while BUSY, late ack afterwards is ignored.
        issue(1'b0, 32'h0000_0040, 32'h0, 32'h9999_9999);
        void'(bus_q.pop_front());
        void'(rd_q.pop_front());
        last_rd = '0;
        @(negedge clk);
        #1;
        check_eq("rbusy_req", 64'(mem_req), 64'(1'b1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rbusy_stall", 64'(stall), 64'(1'b0));
        @(negedge clk);
        rst = 1'b0; cpu_en = 1'b0;
        #1;
        check_eq("rpost_req", 64'(mem_req), 64'(1'b0));
        check_eq("rpost_rdata", 64'(cpu_rdata), 64'(0));
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
        #1;
        check_eq("rlate_req", 64'(mem_req), 64'(1'b0));
        idle_cycle();
        check_eq("rlate_rdata", 64'(cpu_rdata), 64'(0));
        issue(1'b1, 32'h0000_0044, 32'h2468_ACE0, 32'h0);
        busy(1, 32'h1111_1111);
        resp(0);
        idle_cycle();

`ifdef DM_BRIDGE_TIMEOUT_EN
        // No ack: abort after TMO BUSY cycles.
        issue(1'b0, 32'h0000_0080, 32'h0, 32'hDEAD_BEEF);
        void'(bus_q.pop_front());
        void'(rd_q.pop_front());
        for (int unsigned k = 0; k < TMO; k++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            check_eq("tmo_req", 64'(mem_req), 64'(1'b1));
            check_eq("tmo_noerr", 64'(err), 64'(1'b0));
        end
        @(negedge clk);
        #1;
        check_eq("tmo_drop", 64'(mem_req), 64'(1'b0));
        check_eq("tmo_err", 64'(err), 64'(1'b1));
        check_eq("tmo_rdata", 64'(cpu_rdata), 64'(32'hDEAD_BEEF));
        check_eq("tmo_stall", 64'(stall), 64'(1'b0));
        idle_cycle();
        check_eq("tmo_errpulse", 64'(err), 64'(1'b0));

        // Ack in the same cycle as the limit: normal completion.
        issue(1'b0, 32'h0000_0084, 32'h0, 32'h600D_DA7A);
        busy(TMO, 32'h600D_DA7A);
        resp(0);
        idle_cycle();
`endif

        @(negedge clk);
        check_eq("req_count", 64'(rises), 64'(exp_rises));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
